// File: rtl/fft_frame_loader.sv
// ---------------------------------------------------------------------------
// fft_frame_loader
//
// Streaming front-end for fft_top. ADC samples arrive on a valid/ready
// handshake, are sign-extended by one bit and written into NB RAM banks
// through one-hot per-bank write strobes and a shared write address. After
// exactly N samples the loader pulses oSTART once, then refuses input until
// the FFT has taken the start and reported ready again.
//
// Build option:
//   FFT_LOADER_INTERLEAVE_EN  defined   -> interleaved mapping,
//                                          bank = k mod NB, addr = k / NB
//                             undefined -> block mapping,
//                                          bank = k / (N/NB), addr = k mod (N/NB)
//
// Parameters:
//   N   frame length in samples (power of 2, >= 4*NB)
//   NB  number of RAM banks (power of 2, >= 2)
//   DW  ADC sample width; oDATA is DW+1 bits
//   AW  per-bank address width, $clog2(N/NB)
//   CW  drop counter width
//
// Ports:
//   iCLK        clock
//   iRESET      asynchronous active-low reset
//   iSAMPLE     signed ADC sample
//   iVALID      sample present this cycle
//   oREADY      loader accepts a sample this cycle
//   oDATA       sign-extended sample to all banks
//   oADDR_WR    shared bank write address
//   oWE         one-hot per-bank write enable
//   oSTART      one-cycle FFT launch pulse
//   iFFT_RDY    fft_top ready level (high when idle/done)
//   oBUSY       high from launch until FFT completion
//   oFRAME_CNT  frames launched, wraps at 256
//   oDROP       sticky flag: a sample was offered while not ready
//   oDROP_CNT   dropped sample count, saturating
// ---------------------------------------------------------------------------
module fft_frame_loader #(
    parameter int N  = 4096,
    parameter int NB = 4,
    parameter int DW = 15,
    parameter int AW = $clog2(N / NB),
    parameter int CW = 16
) (
    input  logic          iCLK,
    input  logic          iRESET,
    input  logic [DW-1:0] iSAMPLE,
    input  logic          iVALID,
    output logic          oREADY,
    output logic [DW:0]   oDATA,
    output logic [AW-1:0] oADDR_WR,
    output logic [NB-1:0] oWE,
    output logic          oSTART,
    input  logic          iFFT_RDY,
    output logic          oBUSY,
    output logic [7:0]    oFRAME_CNT,
    output logic          oDROP,
    output logic [CW-1:0] oDROP_CNT
);

    localparam int BW = $clog2(NB);
    localparam int KW = AW + BW;

    typedef enum logic [1:0] {
        FILL,
        LAUNCH,
        WAIT_ACK,
        WAIT_DONE
    } state_t;

    state_t        r_state;
    state_t        w_nextState;

    logic [KW-1:0] r_k;
    logic [1:0]    r_ackCnt;
    logic [NB-1:0] r_we;
    logic [AW-1:0] r_addr;
    logic [DW:0]   r_data;
    logic          r_start;
    logic          r_busy;
    logic [7:0]    r_frameCnt;
    logic          r_drop;
    logic [CW-1:0] r_dropCnt;

    logic          w_accept;
    logic          w_drop;
    logic          w_lastSample;
    logic          w_fftDone;
    logic [BW-1:0] w_bank;
    logic [AW-1:0] w_addr;
    logic [NB-1:0] w_weOneHot;

    // Only FILL takes samples; anything offered in the other states is a drop.
    assign w_accept     = iVALID & (r_state == FILL);
    assign w_drop       = iVALID & (r_state != FILL);
    assign w_lastSample = (r_k == KW'(N - 1));
    assign w_fftDone    = (r_state == WAIT_DONE) & iFFT_RDY;

    // The sample index splits into bank and address fields; which half is
    // the bank decides between interleaved and block order.
`ifdef FFT_LOADER_INTERLEAVE_EN
    assign w_bank = r_k[BW-1:0];
    assign w_addr = r_k[KW-1:BW];
`else
    assign w_bank = r_k[KW-1:AW];
    assign w_addr = r_k[AW-1:0];
`endif

    assign w_weOneHot = NB'(1) << w_bank;

    // Ready is forced low while reset is held so upstream never sees a
    // handshake before the loader is live.
    assign oREADY     = (r_state == FILL) & iRESET;
    assign oDATA      = r_data;
    assign oADDR_WR   = r_addr;
    assign oWE        = r_we;
    assign oSTART     = r_start;
    assign oBUSY      = r_busy;
    assign oFRAME_CNT = r_frameCnt;
    assign oDROP      = r_drop;
    assign oDROP_CNT  = r_dropCnt;

    // State register.
    always_ff @(posedge iCLK or negedge iRESET) begin
        if (!iRESET) begin
            r_state <= FILL;
        end else begin
            r_state <= w_nextState;
        end
    end

    // Next-state logic. WAIT_ACK gives the FFT four cycles to drop its ready;
    // if it never does, the start is assumed taken so the loader cannot hang.
    always_comb begin
        w_nextState = r_state;
        case (r_state)
            FILL: begin
                if (w_accept && w_lastSample) begin
                    w_nextState = LAUNCH;
                end
            end
            LAUNCH: begin
                w_nextState = WAIT_ACK;
            end
            WAIT_ACK: begin
                if (!iFFT_RDY || (r_ackCnt == 2'd3)) begin
                    w_nextState = WAIT_DONE;
                end
            end
            WAIT_DONE: begin
                if (iFFT_RDY) begin
                    w_nextState = FILL;
                end
            end
            default: begin
                w_nextState = FILL;
            end
        endcase
    end

    // Sample index and write stage. k wraps to 0 by itself after the last
    // sample because N is a power of two. Address and data only move on an
    // accept so they hold their last value between writes.
    always_ff @(posedge iCLK or negedge iRESET) begin
        if (!iRESET) begin
            r_k    <= '0;
            r_we   <= '0;
            r_addr <= '0;
            r_data <= '0;
        end else begin
            r_we <= w_accept ? w_weOneHot : '0;
            if (w_accept) begin
                r_k    <= r_k + 1'b1;
                r_addr <= w_addr;
                r_data <= {iSAMPLE[DW-1], iSAMPLE};
            end
        end
    end

    // Launch bookkeeping. The start pulse is issued from LAUNCH so it lands
    // one cycle after the final write strobe; busy and the frame count move
    // on the same edge.
    always_ff @(posedge iCLK or negedge iRESET) begin
        if (!iRESET) begin
            r_start    <= 1'b0;
            r_busy     <= 1'b0;
            r_frameCnt <= '0;
            r_ackCnt   <= '0;
        end else begin
            r_start  <= (r_state == LAUNCH);
            r_ackCnt <= (r_state == WAIT_ACK) ? r_ackCnt + 2'd1 : 2'd0;
            if (r_state == LAUNCH) begin
                r_busy     <= 1'b1;
                r_frameCnt <= r_frameCnt + 8'd1;
            end else if (w_fftDone) begin
                r_busy <= 1'b0;
            end
        end
    end

    // Drop tracking: sticky flag plus a counter that stops at all-ones.
    always_ff @(posedge iCLK or negedge iRESET) begin
        if (!iRESET) begin
            r_drop    <= 1'b0;
            r_dropCnt <= '0;
        end else if (w_drop) begin
            r_drop <= 1'b1;
            if (r_dropCnt != {CW{1'b1}}) begin
                r_dropCnt <= r_dropCnt + CW'(1);
            end
        end
    end

endmodule

// File: tb/tb_fft_frame_loader.sv
// ---------------------------------------------------------------------------
// tb_fft_frame_loader
//
// Scoreboard bench for fft_frame_loader. A reference model, clocked on the
// same edges as the DUT, decides from the handshake rules which samples are
// accepted and pushes the expected bank write for each into a queue. A
// separate monitor looks at the outputs just after every edge and pops and
// compares whenever a write is due, and also tracks ready, start, busy,
// frame count and drop state. A small FFT responder drives iFFT_RDY.
// ---------------------------------------------------------------------------
module tb_fft_frame_loader;

    localparam int NB = 4;
    localparam int DW = 15;
    localparam int CW = 16;
`ifdef FFT_LOADER_INTERLEAVE_EN
    localparam int N = 16;
`else
    localparam int N = 4096;
`endif
    localparam int AW = $clog2(N / NB);
    localparam int DEPTH = N / NB;
    localparam int RESET_AT = (N > 2000) ? 2000 : N / 2;

    logic          iCLK = 1'b0;
    logic          iRESET = 1'b1;
    logic [DW-1:0] iSAMPLE = '0;
    logic          iVALID = 1'b0;
    logic          iFFT_RDY = 1'b1;
    logic          oREADY;
    logic [DW:0]   oDATA;
    logic [AW-1:0] oADDR_WR;
    logic [NB-1:0] oWE;
    logic          oSTART;
    logic          oBUSY;
    logic [7:0]    oFRAME_CNT;
    logic          oDROP;
    logic [CW-1:0] oDROP_CNT;

    fft_frame_loader #(
        .N (N),
        .NB(NB),
        .DW(DW),
        .AW(AW),
        .CW(CW)
    ) dut (
        .iCLK      (iCLK),
        .iRESET    (iRESET),
        .iSAMPLE   (iSAMPLE),
        .iVALID    (iVALID),
        .oREADY    (oREADY),
        .oDATA     (oDATA),
        .oADDR_WR  (oADDR_WR),
        .oWE       (oWE),
        .oSTART    (oSTART),
        .iFFT_RDY  (iFFT_RDY),
        .oBUSY     (oBUSY),
        .oFRAME_CNT(oFRAME_CNT),
        .oDROP     (oDROP),
        .oDROP_CNT (oDROP_CNT)
    );

    always #5 iCLK = ~iCLK;

    typedef struct {
        int            tag;
        logic [NB-1:0] we;
        logic [AW-1:0] addr;
        logic [DW:0]   data;
    } wr_t;

    wr_t expQ[$];
    int  startQ[$];

    int total = 0;
    int bad = 0;
    int edgeNo = 0;

    // Reference model state
    int mK = 0;
    int mFrames = 0;
    int mDrops = 0;
    bit mDropFlag = 0;
    bit mBusy = 0;
    bit mWaiting = 0;
    int mLastEdge = 0;
    int mAckEdge = -1;

    // Directed data override for the sign-extension sweep
    bit          overrideEn = 0;
    logic [DW:0] overrideData = '0;
    logic [DW-1:0] sweepIn[3];
    logic [DW:0]   sweepExp[3];

    // FFT responder configuration
    int fftLowCycles = 20;
    bit fftNeverAck = 0;

    task automatic checkOutput(input string name, input logic [63:0] actual,
                               input logic [63:0] expected);
        total++;
        if (actual !== expected) begin
            bad++;
            $display("[TB] FAIL %s: got %0h expected %0h (edge %0d)", name, actual, expected, edgeNo);
        end
    endtask

    function automatic logic [DW:0] signExtend(input logic [DW-1:0] s);
        int v;
        v = int'(s);
        if (v >= (1 << (DW - 1))) v = v - (1 << DW);
        return v[DW:0];
    endfunction

    task automatic modelClear();
        mK = 0;
        mFrames = 0;
        mDrops = 0;
        mDropFlag = 0;
        mBusy = 0;
        mWaiting = 0;
        mAckEdge = -1;
        expQ.delete();
        startQ.delete();
    endtask

    // One clock edge of the reference model, written as rules on edge numbers
    // counted from the frame's last accepted sample L: launch effects at L+1,
    // acknowledge on the first low ready from L+2 or forced at L+5, then
    // completion on the first high ready after that.
    task automatic modelStep();
        bit  readyNow;
        wr_t w;
        int  bank;
        int  addr;
        readyNow = !mWaiting;
        if (mWaiting) begin
            if (edgeNo == mLastEdge + 1) begin
                mBusy = 1;
                mFrames = (mFrames + 1) % 256;
            end else if (mAckEdge < 0) begin
                if (!iFFT_RDY || edgeNo == mLastEdge + 5) mAckEdge = edgeNo;
            end else if (iFFT_RDY) begin
                mWaiting = 0;
                mBusy = 0;
            end
        end
        if (iVALID) begin
            if (readyNow) begin
`ifdef FFT_LOADER_INTERLEAVE_EN
                bank = mK % NB;
                addr = mK / NB;
`else
                bank = mK / DEPTH;
                addr = mK % DEPTH;
`endif
                w.tag = edgeNo;
                w.we = '0;
                w.we[bank] = 1'b1;
                w.addr = AW'(addr);
                w.data = overrideEn ? overrideData : signExtend(iSAMPLE);
                expQ.push_back(w);
                mK++;
                if (mK == N) begin
                    mK = 0;
                    mWaiting = 1;
                    mLastEdge = edgeNo;
                    mAckEdge = -1;
                    startQ.push_back(edgeNo + 1);
                end
            end else begin
                mDropFlag = 1;
                if (mDrops < (1 << CW) - 1) mDrops++;
            end
        end
    endtask

    always @(posedge iCLK) begin
        edgeNo++;
        if (iRESET) modelStep();
    end

    // Monitor: compares outputs just after each edge.
    initial begin : monitor
        wr_t w;
        bit  expStart;
        forever begin
            @(posedge iCLK);
            #1;
            if (iRESET) begin
                if (expQ.size() > 0 && expQ[0].tag == edgeNo) begin
                    w = expQ.pop_front();
                    checkOutput("we", 64'(oWE), 64'(w.we));
                    checkOutput("addr", 64'(oADDR_WR), 64'(w.addr));
                    checkOutput("data", 64'(oDATA), 64'(w.data));
                end else begin
                    checkOutput("we_idle", 64'(oWE), 64'(0));
                end
                expStart = (startQ.size() > 0) && (startQ[0] == edgeNo);
                if (expStart) void'(startQ.pop_front());
                checkOutput("start", 64'(oSTART), 64'(expStart));
                checkOutput("ready", 64'(oREADY), 64'(!mWaiting));
                checkOutput("busy", 64'(oBUSY), 64'(mBusy));
                checkOutput("frame_cnt", 64'(oFRAME_CNT), 64'(mFrames));
                checkOutput("drop", 64'(oDROP), 64'(mDropFlag));
                checkOutput("drop_cnt", 64'(oDROP_CNT), 64'(mDrops));
            end
        end
    end

    // FFT responder: on seeing the start pulse, drop ready for a while.
    initial begin : fftModel
        forever begin
            @(posedge iCLK);
            #1;
            if (oSTART === 1'b1 && !fftNeverAck && iRESET) begin
                iFFT_RDY = 1'b0;
                repeat (fftLowCycles) @(posedge iCLK);
                #1;
                iFFT_RDY = 1'b1;
            end
        end
    end

    task automatic applyStimulus(input bit valid, input logic [DW-1:0] sample,
                                 input bit ov, input logic [DW:0] ovData);
        @(negedge iCLK);
        iVALID = valid;
        iSAMPLE = sample;
        overrideEn = ov;
        overrideData = ovData;
    endtask

    task automatic checkResetOutputs();
        checkOutput("rst_ready", 64'(oREADY), 64'(0));
        checkOutput("rst_we", 64'(oWE), 64'(0));
        checkOutput("rst_start", 64'(oSTART), 64'(0));
        checkOutput("rst_busy", 64'(oBUSY), 64'(0));
        checkOutput("rst_data", 64'(oDATA), 64'(0));
        checkOutput("rst_addr", 64'(oADDR_WR), 64'(0));
        checkOutput("rst_frame_cnt", 64'(oFRAME_CNT), 64'(0));
        checkOutput("rst_drop", 64'(oDROP), 64'(0));
        checkOutput("rst_drop_cnt", 64'(oDROP_CNT), 64'(0));
    endtask

    // Feed one full frame and wait until the loader is back in FILL.
    task automatic runFrame(input int target, input bit randomGaps,
                            input bit holdDuringWait, input bit sweep);
        bit done;
        done = 0;
        for (int c = 0; c < 4 * N + 2000 && !done; c++) begin
            if (mFrames == target && !mWaiting) begin
                done = 1;
            end else if (mWaiting) begin
                applyStimulus(holdDuringWait, DW'($urandom), 0, '0);
            end else if (sweep && mK < 3) begin
                applyStimulus(1, sweepIn[mK], 1, sweepExp[mK]);
            end else if (randomGaps) begin
                applyStimulus($urandom_range(3, 0) != 0, DW'($urandom), 0, '0);
            end else begin
                applyStimulus(1, DW'(mK), 0, '0);
            end
        end
        checkOutput("frame_done", 64'(done), 64'(1));
        checkOutput("frame_queue_empty", 64'(expQ.size()), 64'(0));
    endtask

    initial begin : stimulus
        sweepIn[0] = '1;
        sweepIn[1] = 15'h4000;
        sweepIn[2] = 15'h3FFF;
        sweepExp[0] = 16'hFFFF;
        sweepExp[1] = 16'hC000;
        sweepExp[2] = 16'h3FFF;

        #2;
        iRESET = 1'b0;
        #1;
        checkResetOutputs();
        repeat (3) @(posedge iCLK);
        @(negedge iCLK);
        iRESET = 1'b1;
        #1;
        checkOutput("ready_after_reset", 64'(oREADY), 64'(1));

        // Frame 1: back-to-back samples 0..N-1, short FFT busy period
        fftLowCycles = 20;
        runFrame(1, 0, 0, 0);

        // Frame 2: sign-extension sweep, random gaps, valid held through wait
        fftLowCycles = 100;
        runFrame(2, 1, 1, 1);

        // Frame 3: FFT never drops ready, acknowledge timeout path
        fftNeverAck = 1;
        runFrame(3, 1, 0, 0);
        fftNeverAck = 0;

        // Reset in the middle of a fill
        for (int c = 0; c < 4 * RESET_AT + 100 && mK < RESET_AT; c++) begin
            applyStimulus(1, DW'($urandom), 0, '0);
        end
        @(negedge iCLK);
        iVALID = 1'b0;
        iRESET = 1'b0;
        #1;
        checkResetOutputs();
        modelClear();
        @(negedge iCLK);
        iRESET = 1'b1;
        for (int i = 0; i < 6; i++) applyStimulus(1, DW'($urandom), 0, '0);
        for (int i = 0; i < 3; i++) applyStimulus(0, '0, 0, '0);
        checkOutput("final_queue_empty", 64'(expQ.size()), 64'(0));

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
